// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks (receiver state encoding,
// default oversampling ratio, baud-divisor helper).
package uart_pkg;

  // Receiver FSM state encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  localparam int DEFAULT_OVERSAMPLE = 16;

  // Clock cycles per oversample tick, rounded to nearest
  // (50 MHz, 9600 baud, 16x -> 326).
  function automatic int baud_divisor(input int clk_hz, input int baud, input int oversample);
    int denom;
    denom = baud * oversample;
    return (clk_hz + denom / 2) / denom;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider producing a one-cycle oversample tick
// every DIVISOR clocks. Shared by the receiver and transmitter.
module uart_baud_gen #(
  parameter int DIVISOR = 326
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] count_reg;

  // Count 0..DIVISOR-1 and wrap; never realigned to frame boundaries.
  always_ff @(posedge i_clock) begin
    if (i_reset || count_reg == CW'(DIVISOR - 1)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign o_tick = (count_reg == CW'(DIVISOR - 1));

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receiver, LSB first, 8N1 by default.
// Define UART_RX_PARITY_EN to expect an even-parity bit after the data bits;
// otherwise the frame has no parity bit and o_parity_err stays 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int DIVISOR    = 326,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx,
  output logic [WORD_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_done,
  output logic                  o_frame_err,
  output logic                  o_parity_err
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WORD_WIDTH + 1);

  logic                  tick;
  logic                  rx_meta_reg;
  logic                  rx_s;
  rx_state_t             state_reg;
  logic [SW-1:0]         sample_cnt_reg;
  logic [BW-1:0]         bit_cnt_reg;
  logic [WORD_WIDTH-1:0] shift_reg;
  logic [WORD_WIDTH-1:0] data_reg;
  logic                  done_reg;
  logic                  ferr_reg;
  logic                  mid_bit;
  logic                  end_bit;

  uart_baud_gen #(.DIVISOR(DIVISOR)) baud_gen (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta_reg <= 1'b1;
      rx_s        <= 1'b1;
    end else begin
      rx_meta_reg <= i_rx;
      rx_s        <= rx_meta_reg;
    end
  end

  assign mid_bit = (sample_cnt_reg == SW'(OVERSAMPLE / 2 - 1));
  assign end_bit = (sample_cnt_reg == SW'(OVERSAMPLE - 1));

`ifdef UART_RX_PARITY_EN
  logic parity_bit_reg;
  logic perr_reg;
`endif

  // Frame FSM with registered data and single-cycle status pulses.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_reg      <= IDLE;
      sample_cnt_reg <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      data_reg       <= '0;
      done_reg       <= 1'b0;
      ferr_reg       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_reg <= 1'b0;
      perr_reg       <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      ferr_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_reg      <= START;
            sample_cnt_reg <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (mid_bit) begin
              // Re-check the line mid start bit; a high here was a glitch.
              sample_cnt_reg <= '0;
              bit_cnt_reg    <= '0;
              state_reg      <= rx_s ? IDLE : DATA;
            end else begin
              sample_cnt_reg <= sample_cnt_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (end_bit) begin
              sample_cnt_reg <= '0;
              shift_reg      <= {rx_s, shift_reg[WORD_WIDTH-1:1]};
              bit_cnt_reg    <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == BW'(WORD_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                state_reg <= PARITY;
`else
                state_reg <= STOP;
`endif
              end
            end else begin
              sample_cnt_reg <= sample_cnt_reg + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (end_bit) begin
              sample_cnt_reg <= '0;
              parity_bit_reg <= rx_s;
              state_reg      <= STOP;
            end else begin
              sample_cnt_reg <= sample_cnt_reg + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (end_bit) begin
              sample_cnt_reg <= '0;
              if (rx_s) begin
                data_reg  <= shift_reg;
                done_reg  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                // Even parity: data ones plus parity bit must be even.
                perr_reg  <= (^shift_reg) ^ parity_bit_reg;
`endif
                state_reg <= IDLE;
              end else begin
                ferr_reg  <= 1'b1;
                state_reg <= BREAK;
              end
            end else begin
              sample_cnt_reg <= sample_cnt_reg + 1'b1;
            end
          end
        end
        BREAK: begin
          // Hold off until the line returns high so a stuck-low line
          // cannot retrigger frames.
          if (rx_s) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_rx_data   = data_reg;
  assign o_rx_done   = done_reg;
  assign o_frame_err = ferr_reg;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_reg;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx (DIVISOR=4, OVERSAMPLE=16).
module tb_uart_rx;

  localparam int WW       = 8;
  localparam int DIV      = 4;
  localparam int OS       = 16;
  localparam int BIT_CLKS = DIV * OS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b1;
  logic [WW-1:0] rx_data;
  logic          rx_done;
  logic          frame_err;
  logic          parity_err;

  always #5 clk = ~clk;

  uart_rx #(
    .WORD_WIDTH (WW),
    .DIVISOR    (DIV),
    .OVERSAMPLE (OS)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_rx         (rx),
    .o_rx_data    (rx_data),
    .o_rx_done    (rx_done),
    .o_frame_err  (frame_err),
    .o_parity_err (parity_err)
  );

  typedef struct {
    logic [WW-1:0] data;
    logic          ferr;
    logic          perr;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [WW-1:0] last_good = '0;
  logic          prev_pulse = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Start bit, data LSB first, optional parity, stop bit; line left at stop level.
  task automatic send_frame(input logic [WW-1:0] d, input logic stop_v, input logic par_v);
    bit_time(1'b0);
    for (int i = 0; i < WW; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(par_v);
`else
    if (par_v === 1'bx) $display("note: parity value unused");
`endif
    bit_time(stop_v);
  endtask

  task automatic expect_word(input logic [WW-1:0] d, input logic perr);
    exp_t e;
    e.data = d; e.ferr = 1'b0; e.perr = perr;
    exp_q.push_back(e);
    last_good = d;
  endtask

  task automatic expect_ferr();
    exp_t e;
    e.data = last_good; e.ferr = 1'b1; e.perr = 1'b0;
    exp_q.push_back(e);
  endtask

  // Monitor: every status pulse pops one expected entry.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (rx_done || frame_err || parity_err) begin
        check_val("excl", {31'd0, rx_done & frame_err}, 0);
        check_val("no_back2back", {31'd0, prev_pulse}, 0);
        check_val("q_nonempty", {31'd0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_val("data", {24'd0, rx_data}, {24'd0, mon_e.data});
          check_val("done", {31'd0, rx_done}, {31'd0, ~mon_e.ferr});
          check_val("ferr", {31'd0, frame_err}, {31'd0, mon_e.ferr});
          check_val("perr", {31'd0, parity_err}, {31'd0, mon_e.perr});
          $display("rx: data=%02h done=%0b ferr=%0b perr=%0b", rx_data, rx_done, frame_err, parity_err);
        end
      end
      prev_pulse = rx_done | frame_err | parity_err;
    end
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check_val("rst_data", {24'd0, rx_data}, 0);
    check_val("rst_done", {31'd0, rx_done}, 0);
    check_val("rst_ferr", {31'd0, frame_err}, 0);
    check_val("rst_perr", {31'd0, parity_err}, 0);
    rst = 1'b0;
    bit_time(1'b1);

    // 1: plain frame
    expect_word(8'h55, 1'b0);
    send_frame(8'h55, 1'b1, ^8'h55);
    bit_time(1'b1);

    // 2: short low glitch is rejected, then a normal frame
    rx = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    bit_time(1'b1);
    bit_time(1'b1);
    check_val("glitch_idle", {29'd0, dut.state_reg}, {29'd0, uart_pkg::IDLE});
    expect_word(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    bit_time(1'b1);

    // 3: bad stop bit, long break, recovery
    expect_ferr();
    send_frame(8'hF0, 1'b0, ^8'hF0);
    rx = 1'b0;
    repeat (40 * DIV) @(negedge clk);
    bit_time(1'b1);
    bit_time(1'b1);
    expect_word(8'h12, 1'b0);
    send_frame(8'h12, 1'b1, ^8'h12);
    bit_time(1'b1);

    // 4: back-to-back frames
    expect_word(8'hA3, 1'b0);
    expect_word(8'h0F, 1'b0);
    send_frame(8'hA3, 1'b1, ^8'hA3);
    send_frame(8'h0F, 1'b1, ^8'h0F);
    bit_time(1'b1);

    // 5: reset in the middle of the 4th data bit
    bit_time(1'b0);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b1);
    rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check_val("mid_rst_data", {24'd0, rx_data}, 0);
    check_val("mid_rst_done", {31'd0, rx_done}, 0);
    check_val("mid_rst_ferr", {31'd0, frame_err}, 0);
    check_val("mid_rst_perr", {31'd0, parity_err}, 0);
    rst = 1'b0;
    last_good = '0;
    repeat (3) bit_time(1'b1);
    expect_word(8'h81, 1'b0);
    send_frame(8'h81, 1'b1, ^8'h81);
    bit_time(1'b1);

`ifdef UART_RX_PARITY_EN
    // 6: good and bad parity
    expect_word(8'h07, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    bit_time(1'b1);
    expect_word(8'h07, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    bit_time(1'b1);
`endif

    bit_time(1'b1);
    check_val("q_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
